// File: rtl/thor2024_pma_checker.sv
// thor2024_pma_checker: two-stage physical memory attribute checker with sticky first-fault capture
module thor2024_pma_checker #(
    parameter int ABITS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ABITS-1:0] req_adr,
    input  logic [1:0]       req_acc,
    input  logic [1:0]       req_om,
    input  logic [2:0]       req_rgn,
    output logic [2:0]       rgn,
    input  logic [15:0]      rgn_rwx,
    input  logic [31:0]      rgn_dev,
    input  logic             rgn_err,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ABITS-1:0] rsp_adr,
    output logic             rsp_fault,
    output logic [2:0]       rsp_cause,
    output logic             rsp_cache,
    output logic             flt_valid,
    output logic [ABITS-1:0] flt_adr,
    output logic [2:0]       flt_cause,
    input  logic             clr_flt,
    output logic [15:0]      fault_cnt
);
    logic             s1_valid_q, s1_valid_d;
    logic [ABITS-1:0] s1_adr_q, s1_adr_d;
    logic [1:0]       s1_acc_q, s1_acc_d;
    logic [1:0]       s1_om_q, s1_om_d;
    logic [2:0]       s1_rgn_q, s1_rgn_d;
    logic             s2_valid_q, s2_valid_d;
    logic [ABITS-1:0] s2_adr_q, s2_adr_d;
    logic             s2_fault_q, s2_fault_d;
    logic [2:0]       s2_cause_q, s2_cause_d;
    logic             s2_cache_q, s2_cache_d;
    logic             flt_valid_q, flt_valid_d;
    logic [ABITS-1:0] flt_adr_q, flt_adr_d;
    logic [2:0]       flt_cause_q, flt_cause_d;
    logic [15:0]      fault_cnt_q, fault_cnt_d;
    logic             stall, acc_req, s2_load, flt_hs, flt_cap;
    logic [3:0]       rwx;
    logic [7:0]       dev;
    logic [2:0]       cause;

    always_comb begin
        stall       = s2_valid_q && !rsp_ready;
        req_ready   = !s1_valid_q || !stall;
        acc_req     = req_valid && req_ready;
        rwx         = rgn_rwx[{s1_om_q, 2'b00} +: 4];
        dev         = rgn_dev[{s1_om_q, 3'b000} +: 8];
        cause       = rgn_err ? 3'd1 : dev == 8'hFF ? 3'd2 : s1_acc_q == 2'd3 ? 3'd6 :
                      (s1_acc_q == 2'd0 && !rwx[2]) ? 3'd3 :
                      (s1_acc_q == 2'd1 && !rwx[1]) ? 3'd4 :
                      (s1_acc_q == 2'd2 && !rwx[0]) ? 3'd5 : 3'd0;
        s1_valid_d  = req_ready ? req_valid : s1_valid_q;
        s1_adr_d    = acc_req ? req_adr : s1_adr_q;
        s1_acc_d    = acc_req ? req_acc : s1_acc_q;
        s1_om_d     = acc_req ? req_om : s1_om_q;
        s1_rgn_d    = acc_req ? req_rgn : s1_rgn_q;
        // A bubble advancing into S2 only clears valid; the result fields keep their old values
        s2_valid_d  = stall ? s2_valid_q : s1_valid_q;
        s2_load     = !stall && s1_valid_q;
        s2_adr_d    = s2_load ? s1_adr_q : s2_adr_q;
        s2_cause_d  = s2_load ? cause : s2_cause_q;
        s2_fault_d  = s2_load ? cause != 3'd0 : s2_fault_q;
        s2_cache_d  = s2_load ? rwx[3] && cause == 3'd0 : s2_cache_q;
        flt_hs      = s2_valid_q && rsp_ready && s2_fault_q;
        flt_cap     = flt_hs && (!flt_valid_q || clr_flt);
        flt_valid_d = flt_cap || (flt_valid_q && !clr_flt);
        flt_adr_d   = flt_cap ? s2_adr_q : flt_adr_q;
        flt_cause_d = flt_cap ? s2_cause_q : flt_cause_q;
        fault_cnt_d = (flt_hs && fault_cnt_q != 16'hFFFF) ? fault_cnt_q + 16'd1 : fault_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_adr_q    <= '0;
            s1_acc_q    <= '0;
            s1_om_q     <= '0;
            s1_rgn_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_adr_q    <= '0;
            s2_fault_q  <= 1'b0;
            s2_cause_q  <= '0;
            s2_cache_q  <= 1'b0;
            flt_valid_q <= 1'b0;
            flt_adr_q   <= '0;
            flt_cause_q <= '0;
            fault_cnt_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_adr_q    <= s1_adr_d;
            s1_acc_q    <= s1_acc_d;
            s1_om_q     <= s1_om_d;
            s1_rgn_q    <= s1_rgn_d;
            s2_valid_q  <= s2_valid_d;
            s2_adr_q    <= s2_adr_d;
            s2_fault_q  <= s2_fault_d;
            s2_cause_q  <= s2_cause_d;
            s2_cache_q  <= s2_cache_d;
            flt_valid_q <= flt_valid_d;
            flt_adr_q   <= flt_adr_d;
            flt_cause_q <= flt_cause_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign rgn       = s1_rgn_q;
    assign rsp_valid = s2_valid_q;
    assign rsp_adr   = s2_adr_q;
    assign rsp_fault = s2_fault_q;
    assign rsp_cause = s2_cause_q;
    assign rsp_cache = s2_cache_q;
    assign flt_valid = flt_valid_q;
    assign flt_adr   = flt_adr_q;
    assign flt_cause = flt_cause_q;
    assign fault_cnt = fault_cnt_q;
endmodule

// File: tb/tb_thor2024_pma_checker.sv
// tb_thor2024_pma_checker: vector table, random traffic against a queue model, and corner sequences
module tb_thor2024_pma_checker;
    typedef struct {
        logic [31:0] adr;
        logic [1:0]  acc;
        logic [1:0]  om;
        logic [2:0]  r;
        logic [3:0]  rwx;
        logic [7:0]  dev;
        logic        err;
        logic        fault;
        logic [2:0]  cause;
        logic        cache;
    } vec_t;
    typedef struct {
        logic [31:0] adr;
        logic        fault;
        logic [2:0]  cause;
        logic        cache;
    } rsp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, clr_flt = 1'b0;
    logic [31:0] req_adr = '0, rsp_adr, flt_adr;
    logic [1:0]  req_acc = '0, req_om = '0;
    logic [2:0]  req_rgn = '0, rgn, rsp_cause, flt_cause;
    logic [15:0] rgn_rwx, fault_cnt;
    logic [31:0] rgn_dev;
    logic        rgn_err, rsp_fault, rsp_cache, flt_valid;

    logic [3:0]  t_rwx [8][4];
    logic [7:0]  t_dev [8][4];
    logic        t_err [8];

    rsp_t        exp_q [$];
    vec_t        vt [9];
    int          n_cmp = 0, n_err = 0, n_pop = 0;
    logic        m_fv = 1'b0;
    logic [31:0] m_fa = '0;
    logic [2:0]  m_fc = '0;
    logic [15:0] m_cnt = '0;
    logic        prev_stall = 1'b0, acc_last = 1'b0, rdy_last = 1'b0;
    logic [31:0] prev_adr = '0;
    logic [2:0]  prev_cause = '0;

    always #5 clk = ~clk;

    // Behavioural region table answering whatever index the DUT presents
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            rgn_rwx[4*n +: 4] = t_rwx[rgn][n];
            rgn_dev[8*n +: 8] = t_dev[rgn][n];
        end
        rgn_err = t_err[rgn];
    end

    thor2024_pma_checker #(.ABITS(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_adr(req_adr), .req_acc(req_acc), .req_om(req_om), .req_rgn(req_rgn),
        .rgn(rgn), .rgn_rwx(rgn_rwx), .rgn_dev(rgn_dev), .rgn_err(rgn_err),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_adr(rsp_adr),
        .rsp_fault(rsp_fault), .rsp_cause(rsp_cause), .rsp_cache(rsp_cache),
        .flt_valid(flt_valid), .flt_adr(flt_adr), .flt_cause(flt_cause),
        .clr_flt(clr_flt), .fault_cnt(fault_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic rsp_t model(input logic [31:0] a, input logic [1:0] acc, input logic [1:0] om,
                                   input logic [2:0] r);
        rsp_t e;
        logic [3:0] p;
        logic need;
        p = t_rwx[r][om];
        need = (acc == 2'd0) ? p[2] : (acc == 2'd1) ? p[1] : p[0];
        e.adr = a;
        if (t_err[r]) e.cause = 3'd1;
        else if (t_dev[r][om] == 8'hFF) e.cause = 3'd2;
        else if (acc == 2'd3) e.cause = 3'd6;
        else if (!need) e.cause = 3'd3 + {1'b0, acc};
        else e.cause = 3'd0;
        e.fault = e.cause != 3'd0;
        e.cache = p[3] && !e.fault;
        return e;
    endfunction

    task automatic step(input logic v, input logic [31:0] a, input logic [1:0] acc, input logic [1:0] om,
                        input logic [2:0] r, input logic rr, input logic clr);
        rsp_t e;
        logic nv;
        req_valid = v; req_adr = a; req_acc = acc; req_om = om; req_rgn = r;
        rsp_ready = rr; clr_flt = clr;
        #1;
        chk("flt_valid", flt_valid, m_fv);
        if (m_fv) begin
            chk("flt_adr", flt_adr, m_fa);
            chk("flt_cause", flt_cause, m_fc);
        end
        chk("fault_cnt", fault_cnt, m_cnt);
        if (prev_stall) begin
            chk("stall_valid", rsp_valid, 1);
            chk("stall_adr", rsp_adr, prev_adr);
            chk("stall_cause", rsp_cause, prev_cause);
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_adr = rsp_adr;
        prev_cause = rsp_cause;
        rdy_last = req_ready;
        acc_last = req_valid && req_ready;
        nv = m_fv && !clr;
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) chk("spurious_rsp", rsp_valid, 0);
            else begin
                e = exp_q.pop_front();
                n_pop++;
                chk("rsp_adr", rsp_adr, e.adr);
                chk("rsp_fault", rsp_fault, e.fault);
                chk("rsp_cause", rsp_cause, e.cause);
                chk("rsp_cache", rsp_cache, e.cache);
                if (e.fault) begin
                    if (m_cnt != 16'hFFFF) m_cnt++;
                    if (!m_fv || clr) begin
                        nv = 1'b1; m_fa = e.adr; m_fc = e.cause;
                    end
                end
            end
        end
        m_fv = nv;
        if (acc_last) exp_q.push_back(model(a, acc, om, r));
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) step(0, '0, '0, '0, '0, 1, 0);
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic table_fill();
        for (int r = 0; r < 8; r++) begin
            for (int o = 0; o < 4; o++) begin t_rwx[r][o] = 4'hF; t_dev[r][o] = 8'h00; end
            t_err[r] = 1'b0;
        end
    endtask

    initial begin
        int k, base;
        vt[0] = '{32'h1000_0000, 2'd0, 2'd3, 3'd1, 4'hD, 8'h01, 1'b0, 1'b0, 3'd0, 1'b1};
        vt[1] = '{32'h2000_0040, 2'd1, 2'd0, 3'd2, 4'hD, 8'h00, 1'b0, 1'b1, 3'd4, 1'b0};
        vt[2] = '{32'h3000_0080, 2'd0, 2'd1, 3'd3, 4'hF, 8'hFF, 1'b1, 1'b1, 3'd1, 1'b0};
        vt[3] = '{32'h3000_00C0, 2'd0, 2'd1, 3'd3, 4'hF, 8'hFF, 1'b0, 1'b1, 3'd2, 1'b0};
        vt[4] = '{32'h4000_0100, 2'd3, 2'd2, 3'd5, 4'hF, 8'h10, 1'b0, 1'b1, 3'd6, 1'b0};
        vt[5] = '{32'h5000_0140, 2'd0, 2'd0, 3'd6, 4'hB, 8'h00, 1'b0, 1'b1, 3'd3, 1'b0};
        vt[6] = '{32'h6000_0180, 2'd2, 2'd1, 3'd7, 4'hE, 8'h00, 1'b0, 1'b1, 3'd5, 1'b0};
        vt[7] = '{32'h7000_01C0, 2'd2, 2'd2, 3'd0, 4'h9, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1};
        vt[8] = '{32'h8000_0200, 2'd1, 2'd3, 3'd1, 4'h6, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0};
        table_fill();
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_fault", rsp_fault, 0);
        chk("rst_rsp_cache", rsp_cache, 0);
        chk("rst_rsp_cause", rsp_cause, 0);
        chk("rst_rsp_adr", rsp_adr, 0);
        chk("rst_rgn", rgn, 0);
        chk("rst_flt_valid", flt_valid, 0);
        chk("rst_flt_adr", flt_adr, 0);
        chk("rst_flt_cause", flt_cause, 0);
        chk("rst_fault_cnt", fault_cnt, 0);
        rst_n = 1'b1;
        #1 chk("rst_req_ready", req_ready, 1);
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            t_rwx[vt[i].r][vt[i].om] = vt[i].rwx;
            t_dev[vt[i].r][vt[i].om] = vt[i].dev;
            t_err[vt[i].r] = vt[i].err;
            step(1, vt[i].adr, vt[i].acc, vt[i].om, vt[i].r, 1, 0);
            chk("vec_lat_early", rsp_valid, 0);
            chk("vec_rgn", rgn, vt[i].r);
            step(0, '0, '0, '0, '0, 1, 0);
            chk("vec_valid", rsp_valid, 1);
            chk("vec_adr", rsp_adr, vt[i].adr);
            chk("vec_fault", rsp_fault, vt[i].fault);
            chk("vec_cause", rsp_cause, vt[i].cause);
            chk("vec_cache", rsp_cache, vt[i].cache);
            step(0, '0, '0, '0, '0, 1, 0);
        end
        chk("vec_fault_cnt", fault_cnt, 6);
        chk("vec_flt_valid", flt_valid, 1);
        chk("vec_flt_adr", flt_adr, vt[1].adr);
        chk("vec_flt_cause", flt_cause, 4);

        for (int ep = 0; ep < 8; ep++) begin
            for (int r = 0; r < 8; r++) begin
                for (int o = 0; o < 4; o++) begin
                    t_rwx[r][o] = 4'($urandom);
                    t_dev[r][o] = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom);
                end
                t_err[r] = $urandom_range(0, 7) == 0;
            end
            for (int c = 0; c < 300; c++)
                step($urandom_range(0, 3) != 0, $urandom, 2'($urandom), 2'($urandom), 3'($urandom),
                     $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            drain();
        end

        table_fill();
        k = 0;
        base = n_pop;
        for (int c = 0; c < 20 && k < 4; c++) begin
            step(1, 32'hB000_0000 + 32'(k), 2'd0, 2'd0, 3'd0, c >= 5, 0);
            if (c >= 2 && c <= 4) chk("b2b_ready", rdy_last, 0);
            if (acc_last) k++;
        end
        drain();
        chk("b2b_count", n_pop - base, 4);

        t_err[0] = 1'b1;
        for (int g = 0; g < 70000 && m_cnt != 16'hFFFF; g++) step(1, 32'(g), 2'd0, 2'd0, 3'd0, 1, 0);
        drain();
        step(1, 32'hDEAD_0000, 2'd0, 2'd0, 3'd0, 1, 0);
        drain();
        chk("sat_cnt", fault_cnt, 16'hFFFF);
        step(1, 32'hCAFE_0000, 2'd1, 2'd0, 3'd0, 1, 0);
        step(0, '0, '0, '0, '0, 0, 0);
        step(0, '0, '0, '0, '0, 1, 1);
        chk("clr_hit_valid", flt_valid, 1);
        chk("clr_hit_adr", flt_adr, 32'hCAFE_0000);
        chk("clr_hit_cnt", fault_cnt, 16'hFFFF);

        t_err[0] = 1'b0;
        step(1, 32'hA000_0000, 2'd0, 2'd0, 3'd0, 0, 0);
        step(1, 32'hA000_0004, 2'd0, 2'd0, 3'd0, 0, 0);
        chk("pre_rst_valid", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_cnt", fault_cnt, 0);
        chk("mid_rst_flt", flt_valid, 0);
        exp_q.delete();
        m_fv = 1'b0; m_cnt = '0; prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step(0, '0, '0, '0, '0, 1, 0);
            chk("post_rst_valid", rsp_valid, 0);
        end
        step(1, 32'hE000_0000, 2'd2, 2'd1, 3'd4, 1, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
